// File: rtl/dmem_responder_if.sv
// Purpose : request/response bundle between the core's LW/SW path and the data-memory responder.
// Latency : none; wires only.
// Backpress: req_valid/req_ready and rsp_valid/rsp_ready handshakes, both completing on a rising edge.
// Ports   : master = core side (drives requests, accepts responses),
//           slave  = responder side (accepts requests, drives responses).
interface dmem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Purpose : single-request data-memory responder for LW/SW, word storage of DEPTH x DATA_W.
// Latency : rsp_valid rises LATENCY cycles after the accepting edge.
// Backpress: one request in flight; response (valid/rdata/err) held until rsp_ready, req_ready low until the cycle after.
// Ports   : clk_i, rst_ni (synchronous, active-low), bus (dmem_responder_if.slave), busy_o (request in flight).
// Option  : define DMEM_ALIGN_CHECK_EN to flag odd byte addresses with rsp_err and suppress their access.
module dmem_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  dmem_responder_if.slave       bus,
  output logic                  busy_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                wr_q;
  logic                mis_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mis_d;
  logic                wait_done;
  logic                mem_we;
  logic                unused_addr_bits;

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_d = bus.req_addr[0];
`else
  // The ALU already produces even addresses, so bit 0 carries no information.
  assign mis_d = 1'b0;
`endif

  // Bytes above the word index wrap; they are intentionally dropped.
  assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:IDX_W+1], bus.req_addr[0]};

  assign wait_done = (state_q == WAIT) && (cnt_q == '0);
  // Gated by rst_ni so a reset landing on the commit edge still drops the store.
  assign mem_we    = rst_ni && wait_done && wr_q && !mis_q;

  // Storage has no reset: contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      mis_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            state_q     <= WAIT;
            cnt_q       <= CNT_W'(LATENCY - 1);
            wr_q        <= bus.req_wr;
            mis_q       <= mis_d;
            idx_q       <= bus.req_addr[IDX_W:1];
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end else begin
            // First cycle out of reset raises ready here.
            req_ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            err_q       <= mis_q;
            rdata_q     <= (wr_q || mis_q) ? '0 : mem[idx_q];
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Purpose : scoreboard bench for dmem_responder (LW/SW, wrap, backpressure, reset mid-op, alignment option).
// Latency : checks rsp_valid arrives exactly LAT cycles after each accepting edge.
// Backpress: exercises held responses with rsp_ready low and a blocked req_valid during RESP.
module tb_dmem_responder;

  localparam int LAT = 4;

  logic clk;
  logic rst_n;
  logic busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  dmem_responder #(
    .DATA_W (16),
    .ADDR_W (16),
    .DEPTH  (1024),
    .LATENCY(LAT)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for acceptance, then scramble inputs.
  task automatic send(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [15:0] exp_rd, input logic exp_err);
    int n;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready", {31'd0, bus.req_ready}, 32'd1);
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb.push_back(e);
    tick();
    bus.req_valid = 1'b0;
    bus.req_wr    = ~wr;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wdata;
    chk("accept_busy", {31'd0, busy}, 32'd1);
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall it.
  task automatic expect_rsp(input int hold);
    int   lat;
    exp_t e;
    e.rdata = 16'h0;
    e.err   = 1'b0;
    if (hold > 0) bus.rsp_ready = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.rsp_valid && lat < 50);
    chk("latency", lat, LAT);
    if (sb.size() > 0) e = sb.pop_front();
    chk("rsp_rdata", {16'd0, bus.rsp_rdata}, {16'd0, e.rdata});
    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
      end
      tick();
      chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_rdata", {16'd0, bus.rsp_rdata}, {16'd0, e.rdata});
      chk("bp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("post_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_req_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;

    // Reset and idle.
    tick();
    tick();
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
    chk("rst_err", {31'd0, bus.rsp_err}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Store then load the same word.
    send(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
    expect_rsp(0);
    send(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    expect_rsp(0);

    // Address wrap modulo 2*DEPTH bytes.
    send(1'b1, 16'h0802, 16'h1234, 16'h0000, 1'b0);
    expect_rsp(0);
    send(1'b0, 16'h0002, 16'h0000, 16'h1234, 1'b0);
    expect_rsp(0);

    // Backpressure with a competing request held during RESP.
    send(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    expect_rsp(3);

    // Reset mid-WAIT drops the pending store.
    send(1'b1, 16'h0020, 16'h1111, 16'h0000, 1'b0);
    expect_rsp(0);
    send(1'b1, 16'h0020, 16'hAAAA, 16'h0000, 1'b0);
    void'(sb.pop_back());
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_rel_req_ready", {31'd0, bus.req_ready}, 32'd1);
    send(1'b0, 16'h0020, 16'h0000, 16'h1111, 1'b0);
    expect_rsp(0);

`ifdef DMEM_ALIGN_CHECK_EN
    send(1'b1, 16'h0030, 16'h7777, 16'h0000, 1'b0);
    expect_rsp(0);
    send(1'b1, 16'h0031, 16'h5555, 16'h0000, 1'b1);
    expect_rsp(0);
    send(1'b0, 16'h0030, 16'h0000, 16'h7777, 1'b0);
    expect_rsp(0);
    send(1'b0, 16'h0031, 16'h0000, 16'h0000, 1'b1);
    expect_rsp(2);
`else
    // Odd byte address reads the same word when alignment checking is off.
    send(1'b0, 16'h0003, 16'h0000, 16'h1234, 1'b0);
    expect_rsp(0);
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
